// File: rtl/cache_tag_compare_if.sv
// cache_tag_compare_if
//   Bundles the three handshakes of the tag-compare stage:
//     upstream  : in_valid/in_ready, in_x_addr, in_y_addr, in_chg_luma, in_chg_chma, inv
//     fill      : miss_valid/miss_ready, miss_x_addr, miss_y_addr, miss_set, miss_way, fill_done
//     downstream: out_valid/out_ready, out_hit, out_way, out_set, out_chg_luma, out_chg_chma
//   slave  : the tag-compare stage itself.
//   master : the surrounding pipeline / fill engine (or a testbench).
interface cache_tag_compare_if #(
  parameter int XA_W       = 8,
  parameter int YA_W       = 8,
  parameter int SET_X_BITS = 2,
  parameter int SET_Y_BITS = 2
);
  localparam int SET_W = SET_X_BITS + SET_Y_BITS;

  logic             in_valid;
  logic             in_ready;
  logic [XA_W-1:0]  in_x_addr;
  logic [YA_W-1:0]  in_y_addr;
  logic             in_chg_luma;
  logic             in_chg_chma;
  logic             inv;

  logic             miss_valid;
  logic             miss_ready;
  logic [XA_W-1:0]  miss_x_addr;
  logic [YA_W-1:0]  miss_y_addr;
  logic [SET_W-1:0] miss_set;
  logic             miss_way;
  logic             fill_done;

  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic             out_way;
  logic [SET_W-1:0] out_set;
  logic             out_chg_luma;
  logic             out_chg_chma;

  modport slave (
    input  in_valid, in_x_addr, in_y_addr, in_chg_luma, in_chg_chma, inv,
    output in_ready,
    output miss_valid, miss_x_addr, miss_y_addr, miss_set, miss_way,
    input  miss_ready, fill_done,
    output out_valid, out_hit, out_way, out_set, out_chg_luma, out_chg_chma,
    input  out_ready
  );

  modport master (
    output in_valid, in_x_addr, in_y_addr, in_chg_luma, in_chg_chma, inv,
    input  in_ready,
    input  miss_valid, miss_x_addr, miss_y_addr, miss_set, miss_way,
    output miss_ready, fill_done,
    input  out_valid, out_hit, out_way, out_set, out_chg_luma, out_chg_chma,
    output out_ready
  );
endinterface

// File: rtl/cache_tag_compare.sv
// cache_tag_compare
//   Tag-compare stage of the reference-pixel cache. Looks up one block address
//   per handshake in a 2-way set-associative tag array and forwards a
//   registered hit/way/set result. A miss issues one fill request, stalls
//   upstream until fill_done, then writes the tag and forwards the result.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : cache_tag_compare_if.slave (upstream, fill and downstream handshakes)
//   hit_count, miss_count : 32-bit statistics, present only when the macro
//                CACHE_TAG_STATS_EN is defined (cleared by reset and inv).
module cache_tag_compare #(
  parameter int XA_W       = 8,
  parameter int YA_W       = 8,
  parameter int SET_X_BITS = 2,
  parameter int SET_Y_BITS = 2
) (
  input logic                clk,
  input logic                reset,
  cache_tag_compare_if.slave bus
`ifdef CACHE_TAG_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  localparam int SET_W = SET_X_BITS + SET_Y_BITS;
  localparam int TAG_W = XA_W + YA_W - SET_W;
  localparam int SETS  = 1 << SET_W;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  function automatic logic [SET_W-1:0] set_of(input logic [XA_W-1:0] x, input logic [YA_W-1:0] y);
    return {y[SET_Y_BITS-1:0], x[SET_X_BITS-1:0]};
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [XA_W-1:0] x, input logic [YA_W-1:0] y);
    return {y[YA_W-1:SET_Y_BITS], x[XA_W-1:SET_X_BITS]};
  endfunction

  state_t           state_r, state_s;
  logic [TAG_W-1:0] tag0_r [SETS];
  logic [TAG_W-1:0] tag1_r [SETS];
  logic [SETS-1:0]  valid0_r, valid1_r, lru_r;

  logic [XA_W-1:0]  miss_x_r;
  logic [YA_W-1:0]  miss_y_r;
  logic [SET_W-1:0] miss_set_r;
  logic             miss_way_r, miss_luma_r, miss_chma_r;

  logic             out_valid_r, out_hit_r, out_way_r, out_luma_r, out_chma_r;
  logic [SET_W-1:0] out_set_r;

  logic [SET_W-1:0] set_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit0_s, hit1_s, hit_s, hit_way_s, victim_s;
  logic             in_ready_s, accept_s, inv_s, load_hit_s, load_fill_s;

  // Lookup of the incoming address and victim choice (way0 wins ties).
  always_comb begin
    set_s  = set_of(bus.in_x_addr, bus.in_y_addr);
    tag_s  = tag_of(bus.in_x_addr, bus.in_y_addr);
    hit0_s = valid0_r[set_s] && (tag0_r[set_s] == tag_s);
    hit1_s = valid1_r[set_s] && (tag1_r[set_s] == tag_s);
    hit_s  = hit0_s | hit1_s;
    if (hit0_s) hit_way_s = 1'b0;
    else        hit_way_s = 1'b1;
    if (!valid0_r[set_s])      victim_s = 1'b0;
    else if (!valid1_r[set_s]) victim_s = 1'b1;
    else                       victim_s = lru_r[set_s];
  end

  // inv only takes effect in LOOKUP and blocks acceptance in that cycle.
  assign inv_s       = bus.inv && (state_r == LOOKUP);
  assign in_ready_s  = (state_r == LOOKUP) && !bus.inv && (!out_valid_r || bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign load_hit_s  = accept_s && hit_s;
  assign load_fill_s = (state_r == MISS_WAIT) && bus.fill_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= LOOKUP;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOOKUP:    if (accept_s && !hit_s) state_s = MISS_REQ;  else state_s = LOOKUP;
      MISS_REQ:  if (bus.miss_ready)     state_s = MISS_WAIT; else state_s = MISS_REQ;
      MISS_WAIT: if (bus.fill_done)      state_s = LOOKUP;    else state_s = MISS_WAIT;
      default:   state_s = LOOKUP;
    endcase
  end

  // Tag/valid/LRU array: invalidate, LRU touch on hit, tag write on fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid0_r <= {SETS{1'b0}};
      valid1_r <= {SETS{1'b0}};
      lru_r    <= {SETS{1'b0}};
      for (int i = 0; i < SETS; i++) begin
        tag0_r[i] <= {TAG_W{1'b0}};
        tag1_r[i] <= {TAG_W{1'b0}};
      end
    end else if (inv_s) begin
      valid0_r <= {SETS{1'b0}};
      valid1_r <= {SETS{1'b0}};
      lru_r    <= {SETS{1'b0}};
    end else if (load_hit_s) begin
      lru_r[set_s] <= ~hit_way_s;
    end else if (load_fill_s) begin
      if (miss_way_r) begin
        tag1_r[miss_set_r]   <= tag_of(miss_x_r, miss_y_r);
        valid1_r[miss_set_r] <= 1'b1;
      end else begin
        tag0_r[miss_set_r]   <= tag_of(miss_x_r, miss_y_r);
        valid0_r[miss_set_r] <= 1'b1;
      end
      lru_r[miss_set_r] <= ~miss_way_r;
    end else begin
      lru_r <= lru_r;
    end
  end

  // Miss capture; fields stay stable for the whole request.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_x_r    <= {XA_W{1'b0}};
      miss_y_r    <= {YA_W{1'b0}};
      miss_set_r  <= {SET_W{1'b0}};
      miss_way_r  <= 1'b0;
      miss_luma_r <= 1'b0;
      miss_chma_r <= 1'b0;
    end else if (accept_s && !hit_s) begin
      miss_x_r    <= bus.in_x_addr;
      miss_y_r    <= bus.in_y_addr;
      miss_set_r  <= set_s;
      miss_way_r  <= victim_s;
      miss_luma_r <= bus.in_chg_luma;
      miss_chma_r <= bus.in_chg_chma;
    end else begin
      miss_x_r    <= miss_x_r;
    end
  end

  // Output register. On a fill it is known empty, so the load is unconditional.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_hit_r   <= 1'b0;
      out_way_r   <= 1'b0;
      out_set_r   <= {SET_W{1'b0}};
      out_luma_r  <= 1'b0;
      out_chma_r  <= 1'b0;
    end else if (load_hit_s) begin
      out_valid_r <= 1'b1;
      out_hit_r   <= 1'b1;
      out_way_r   <= hit_way_s;
      out_set_r   <= set_s;
      out_luma_r  <= bus.in_chg_luma;
      out_chma_r  <= bus.in_chg_chma;
    end else if (load_fill_s) begin
      out_valid_r <= 1'b1;
      out_hit_r   <= 1'b0;
      out_way_r   <= miss_way_r;
      out_set_r   <= miss_set_r;
      out_luma_r  <= miss_luma_r;
      out_chma_r  <= miss_chma_r;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef CACHE_TAG_STATS_EN
  // Wrap-around hit/miss statistics.
  always_ff @(posedge clk) begin
    if (reset || inv_s) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (load_hit_s)  hit_count  <= hit_count + 32'd1;
      else             hit_count  <= hit_count;
      if (load_fill_s) miss_count <= miss_count + 32'd1;
      else             miss_count <= miss_count;
    end
  end
`endif

  assign bus.in_ready     = in_ready_s;
  assign bus.miss_valid   = (state_r == MISS_REQ);
  assign bus.miss_x_addr  = miss_x_r;
  assign bus.miss_y_addr  = miss_y_r;
  assign bus.miss_set     = miss_set_r;
  assign bus.miss_way     = miss_way_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_hit      = out_hit_r;
  assign bus.out_way      = out_way_r;
  assign bus.out_set      = out_set_r;
  assign bus.out_chg_luma = out_luma_r;
  assign bus.out_chg_chma = out_chma_r;
endmodule

// File: tb/tb_cache_tag_compare.sv
// Directed testbench for cache_tag_compare. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT updates on the rising edge.
module tb_cache_tag_compare;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef CACHE_TAG_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_tag_compare_if #(.XA_W(8), .YA_W(8), .SET_X_BITS(2), .SET_Y_BITS(2)) bus ();

  cache_tag_compare #(.XA_W(8), .YA_W(8), .SET_X_BITS(2), .SET_Y_BITS(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_TAG_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Full miss sequence: accept, request handshake, fill, result.
  task automatic do_miss(input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] exp_set, input logic exp_way);
    bus.in_valid = 1'b1; bus.in_x_addr = x; bus.in_y_addr = y;
    bus.in_chg_luma = 1'b1; bus.in_chg_chma = 1'b0;
    #1 check("miss_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("miss_valid_rise", bus.miss_valid, 1);
    check("miss_set", bus.miss_set, exp_set);
    check("miss_way", bus.miss_way, exp_way);
    check("miss_x", bus.miss_x_addr, x);
    check("miss_y", bus.miss_y_addr, y);
    check("stall_in_ready", bus.in_ready, 0);
    bus.miss_ready = 1'b1;
    tick();
    bus.miss_ready = 1'b0;
    check("miss_valid_drop", bus.miss_valid, 0);
    check("wait_in_ready", bus.in_ready, 0);
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    check("fill_out_valid", bus.out_valid, 1);
    check("fill_out_hit", bus.out_hit, 0);
    check("fill_out_way", bus.out_way, exp_way);
    check("fill_out_set", bus.out_set, exp_set);
    check("fill_out_luma", bus.out_chg_luma, 1);
    check("fill_in_ready", bus.in_ready, 1);
  endtask

  // Single hit with 1-cycle latency (out_ready held high).
  task automatic do_hit(input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] exp_set, input logic exp_way);
    bus.in_valid = 1'b1; bus.in_x_addr = x; bus.in_y_addr = y;
    bus.in_chg_luma = 1'b0; bus.in_chg_chma = 1'b1;
    #1 check("hit_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("hit_out_valid", bus.out_valid, 1);
    check("hit_out_hit", bus.out_hit, 1);
    check("hit_out_way", bus.out_way, exp_way);
    check("hit_out_set", bus.out_set, exp_set);
    check("hit_out_chma", bus.out_chg_chma, 1);
    check("hit_miss_valid", bus.miss_valid, 0);
  endtask

  logic [7:0] sx [3];
  logic [7:0] sy [3];
  logic [4:0] sexp [3];   // {way, set}
  logic [4:0] sb [$];
  logic [4:0] e;
  int idx, got;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_x_addr = 8'd0; bus.in_y_addr = 8'd0;
    bus.in_chg_luma = 1'b0; bus.in_chg_chma = 1'b0; bus.inv = 1'b0;
    bus.miss_ready = 1'b0; bus.fill_done = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_miss_valid", bus.miss_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_miss_set", bus.miss_set, 0);
    check("rst_out_set", bus.out_set, 0);

    // (5,3): set = {y[1:0]=3, x[1:0]=1} = 0xD
    do_miss(8'd5, 8'd3, 4'hD, 1'b0);
    do_hit (8'd5, 8'd3, 4'hD, 1'b0);

    // Set 1: (1,0)->way0, (5,0)->way1, (9,0)->evicts LRU way0, (1,0)->evicts way1
    do_miss(8'd1, 8'd0, 4'h1, 1'b0);
    do_miss(8'd5, 8'd0, 4'h1, 1'b1);
    do_miss(8'd9, 8'd0, 4'h1, 1'b0);
    do_miss(8'd1, 8'd0, 4'h1, 1'b1);

    // Hit stream with out_ready toggling: (5,3)w0 sD, (9,0)w0 s1, (1,0)w1 s1
    sx[0] = 8'd5; sy[0] = 8'd3; sexp[0] = {1'b0, 4'hD};
    sx[1] = 8'd9; sy[1] = 8'd0; sexp[1] = {1'b0, 4'h1};
    sx[2] = 8'd1; sy[2] = 8'd0; sexp[2] = {1'b1, 4'h1};
    bus.out_ready = 1'b1;
    tick();
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.out_ready = (cyc % 2 == 0);
      bus.in_valid  = (idx < 8);
      bus.in_x_addr = sx[idx % 3];
      bus.in_y_addr = sy[idx % 3];
      #1;
      if (bus.out_valid && !bus.out_ready)
        check("stream_backpressure", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("stream_hit", bus.out_hit, 1);
          check("stream_way_set", {bus.out_way, bus.out_set}, e);
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(sexp[idx % 3]);
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_results", got, 8);
    check("stream_accepts", idx, 8);
    tick();
    check("stream_drained", bus.out_valid, 0);

    // inv together with in_valid: no accept, then cached address misses
    bus.inv = 1'b1; bus.in_valid = 1'b1; bus.in_x_addr = 8'd5; bus.in_y_addr = 8'd3;
    #1 check("inv_in_ready", bus.in_ready, 0);
    tick();
    bus.inv = 1'b0; bus.in_valid = 1'b0;
    check("inv_no_out", bus.out_valid, 0);
    check("inv_no_miss", bus.miss_valid, 0);
    do_miss(8'd5, 8'd3, 4'hD, 1'b0);
    tick();

    // fill_done outside MISS_WAIT is ignored
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    check("stray_fill_out", bus.out_valid, 0);

    // Reset in MISS_WAIT: request abandoned, address misses again
    bus.in_valid = 1'b1; bus.in_x_addr = 8'd2; bus.in_y_addr = 8'd0;
    tick();
    bus.in_valid = 1'b0;
    check("rmw_miss_valid", bus.miss_valid, 1);
    bus.miss_ready = 1'b1;
    tick();
    bus.miss_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmw_miss_valid_low", bus.miss_valid, 0);
    check("rmw_out_valid_low", bus.out_valid, 0);
    check("rmw_in_ready", bus.in_ready, 1);
    do_miss(8'd2, 8'd0, 4'h2, 1'b0);
    tick();

`ifdef CACHE_TAG_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stat_rst_hit", hit_count, 0);
    check("stat_rst_miss", miss_count, 0);
    do_miss(8'd5, 8'd3, 4'hD, 1'b0);
    do_miss(8'd1, 8'd0, 4'h1, 1'b0);
    do_hit (8'd5, 8'd3, 4'hD, 1'b0);
    do_hit (8'd1, 8'd0, 4'h1, 1'b0);
    do_hit (8'd5, 8'd3, 4'hD, 1'b0);
    check("stat_hit", hit_count, 3);
    check("stat_miss", miss_count, 2);
    bus.inv = 1'b1;
    tick();
    bus.inv = 1'b0;
    check("stat_inv_hit", hit_count, 0);
    check("stat_inv_miss", miss_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
